// File: rtl/msx_reload_sequencer_if.sv
// ---------------------------------------------------------------------------
// msx_reload_sequencer_if
// Write port from the reload sequencer to the SDRAM arbiter.
//
//   mem_req   master -> slave  write request
//   mem_addr  master -> slave  byte address inside the cartridge SRAM region
//   mem_data  master -> slave  write data
//   mem_ack   slave  -> master arbiter accepted the current write
//
// Handshake: a write transfers on every rising clk edge where mem_req and
// mem_ack are both high. Once mem_req is raised, mem_req, mem_addr and
// mem_data hold steady until that transfer edge; the master never withdraws
// a pending request. mem_ack while mem_req is low carries no meaning.
// ---------------------------------------------------------------------------
interface msx_reload_sequencer_if;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_data,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_data,
    output mem_ack
  );
endinterface

// File: rtl/msx_reload_sequencer.sv
// ---------------------------------------------------------------------------
// msx_reload_sequencer
// Holds the MSX core in reset whenever the slot/cartridge configuration
// changes or the user asks for a reset, waits for the menu to go quiet,
// clears the cartridge SRAM region through the arbiter write port, then
// keeps reset asserted a little longer before releasing the core.
//
// Ports:
//   clk, reset_n    system clock, asynchronous active-low reset
//   reload          one-cycle pulse: configuration changed
//   user_reset      level: user reset request
//   sram_clear_en   0 skips the SRAM clear (sampled when settling ends)
//   sram_size       cart SRAM size in kB (0 = none, values above 32 clamp)
//   mem             arbiter write port (master side)
//   msx_reset       core reset, active high
//   busy            high whenever the FSM is not IDLE
//   done            one-cycle pulse on the first IDLE cycle after a sequence
//   state_dbg       current FSM state (IDLE=0, SETTLE=1, CLEAR=2, HOLD=3)
// ---------------------------------------------------------------------------
module msx_reload_sequencer #(
  parameter int         SETTLE_CYCLES = 1024,
  parameter int         RESET_CYCLES  = 256,
  parameter logic [7:0] FILL_BYTE     = 8'h00
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          reload,
  input  logic                          user_reset,
  input  logic                          sram_clear_en,
  input  logic [7:0]                    sram_size,
  msx_reload_sequencer_if.master        mem,
  output logic                          msx_reset,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CLEAR  = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  // One counter is shared by SETTLE and HOLD, so it must reach the larger
  // of the two terminal counts.
  localparam int CNT_MAX = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
  localparam int CW      = $clog2((CNT_MAX < 2) ? 2 : CNT_MAX);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] RESET_LAST  = CW'(RESET_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [14:0]   addr_q;
  logic [14:0]   last_addr;
  logic          req_q;
  logic          abort_pend;
  logic          pwr_pend;
  logic          evt;
  logic [5:0]    size_clamped;
  logic [4:0]    size_m1;

  assign evt = reload | user_reset;

  // Sizes above 32 kB clamp to 32 kB. The last address of an N kB region is
  // {N-1, 10'h3FF}, which keeps a 32 kB clear ending at 0x7FFF with no wrap.
  always_comb begin
    size_clamped = (sram_size > 8'd32) ? 6'd32 : sram_size[5:0];
    size_m1      = 5'(size_clamped - 6'd1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      last_addr  <= '0;
      req_q      <= 1'b0;
      abort_pend <= 1'b0;
      pwr_pend   <= 1'b1;
      msx_reset  <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // pwr_pend forces one full sequence after reset_n is released.
          if (evt || pwr_pend) begin
            state     <= SETTLE;
            cnt       <= '0;
            pwr_pend  <= 1'b0;
            msx_reset <= 1'b1;
            busy      <= 1'b1;
          end
        end

        SETTLE: begin
          if (evt) begin
            cnt <= '0;
          end else if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (sram_clear_en && (size_clamped != 6'd0)) begin
              state      <= CLEAR;
              addr_q     <= '0;
              last_addr  <= {size_m1, 10'h3FF};
              req_q      <= 1'b1;
              abort_pend <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CLEAR: begin
          // The request is always up in CLEAR, so an abort is only honoured
          // on the acked edge; an event seen while stalled is remembered.
          if (mem.mem_ack) begin
            if (evt || abort_pend) begin
              state      <= SETTLE;
              cnt        <= '0;
              req_q      <= 1'b0;
              addr_q     <= '0;
              abort_pend <= 1'b0;
            end else if (addr_q == last_addr) begin
              state <= HOLD;
              cnt   <= '0;
              req_q <= 1'b0;
            end else begin
              addr_q <= addr_q + 15'd1;
            end
          end else if (evt) begin
            abort_pend <= 1'b1;
          end
        end

        HOLD: begin
          if (evt) begin
            state <= SETTLE;
            cnt   <= '0;
          end else if (cnt == RESET_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            msx_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_data = FILL_BYTE;
  assign state_dbg    = state;

endmodule

// File: tb/tb_msx_reload_sequencer.sv
module tb_msx_reload_sequencer;
  localparam int S = 8;
  localparam int R = 4;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CLEAR  = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       reload = 1'b0;
  logic       user_reset = 1'b0;
  logic       sram_clear_en = 1'b0;
  logic [7:0] sram_size = 8'd0;
  logic       msx_reset;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  msx_reload_sequencer_if mif();

  msx_reload_sequencer #(
    .SETTLE_CYCLES(S),
    .RESET_CYCLES(R),
    .FILL_BYTE(8'h00)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .reload(reload),
    .user_reset(user_reset),
    .sram_clear_en(sram_clear_en),
    .sram_size(sram_size),
    .mem(mif.master),
    .msx_reset(msx_reset),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [14:0] exp_q[$];
  logic [14:0] exp_a;
  logic [14:0] last_wr_addr = '0;
  logic        prev_stall = 1'b0;
  logic [14:0] prev_addr = '0;

  // ack driver: 0 = low, 1 = high, 2 = random; stop_en parks ack low at stop_addr
  int          ack_mode = 1;
  bit          stop_en = 1'b0;
  logic [14:0] stop_addr = '0;

  initial begin
    mif.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       mif.mem_ack = 1'b0;
        1:       mif.mem_ack = 1'b1;
        default: mif.mem_ack = ($urandom_range(0, 3) != 0);
      endcase
      if (stop_en && mif.mem_addr == stop_addr) mif.mem_ack = 1'b0;
    end
  end

  // Write monitor: every accepted write pops the expected address queue.
  always @(negedge clk) begin
    if (mif.mem_req) begin
      if (prev_stall) begin
        n_cmp++;
        if (mif.mem_addr !== prev_addr) begin
          n_err++;
          $display("FAIL addr_stable: got %0h want %0h", mif.mem_addr, prev_addr);
        end
      end
      if (mif.mem_ack) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got addr %0h want no write", mif.mem_addr);
        end else begin
          exp_a = exp_q.pop_front();
          if (mif.mem_addr !== exp_a || mif.mem_data !== 8'h00) begin
            n_err++;
            $display("FAIL write: got addr %0h data %0h want addr %0h data 00",
                     mif.mem_addr, mif.mem_data, exp_a);
          end
        end
        last_wr_addr <= mif.mem_addr;
      end
    end
    prev_stall <= mif.mem_req && !mif.mem_ack;
    prev_addr  <= mif.mem_addr;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_reload;
    @(posedge clk);
    #1 reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
  endtask

  task automatic push_range(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(15'(i));
  endtask

  task automatic wait_done(input int budget, output bit seen, output int holds);
    seen  = 1'b0;
    holds = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (state_dbg == ST_HOLD) holds++;
      if (done) seen = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({msx_reset, busy, mif.mem_req, done, state_dbg} !== {4'b1100, ST_IDLE}) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want %b",
               {msx_reset, busy, mif.mem_req, done, state_dbg}, {4'b1100, ST_IDLE});
    end
    n_cmp++;
    if (mif.mem_addr !== 15'd0) begin
      n_err++;
      $display("FAIL reset_addr: got %0h want 0", mif.mem_addr);
    end
  endtask

  task automatic test_power_up;
    int hi = 0;
    int dones = 0;
    int holds = 0;
    logic rst_at_done = 1'b1;
    sram_clear_en = 1'b0;
    sram_size     = 8'd0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (msx_reset) hi++;
      if (state_dbg == ST_HOLD) holds++;
      if (done) begin
        dones++;
        rst_at_done = msx_reset;
      end
    end
    n_cmp++;
    if (hi != S + R + 1) begin
      n_err++;
      $display("FAIL pwr_reset_len: got %0d want %0d", hi, S + R + 1);
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL pwr_done_count: got %0d want 1", dones);
    end
    n_cmp++;
    if (rst_at_done !== 1'b0) begin
      n_err++;
      $display("FAIL pwr_rst_at_done: got %b want 0", rst_at_done);
    end
    n_cmp++;
    if (holds != R) begin
      n_err++;
      $display("FAIL pwr_hold_len: got %0d want %0d", holds, R);
    end
  endtask

  task automatic test_reload_idle;
    bit seen;
    int holds;
    sram_clear_en = 1'b1;
    sram_size     = 8'd1;
    ack_mode      = 1;
    push_range(1024);
    pulse_reload();
    wait_done(3000, seen, holds);
    n_cmp++;
    if (!seen || msx_reset !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_done: got seen %b msx_reset %b busy %b want 1 0 0", seen, msx_reset, busy);
    end
    n_cmp++;
    if (exp_q.size() != 0 || last_wr_addr !== 15'd1023) begin
      n_err++;
      $display("FAIL idle_writes: got left %0d last %0h want 0 3ff", exp_q.size(), last_wr_addr);
    end
    n_cmp++;
    if (holds != R) begin
      n_err++;
      $display("FAIL idle_hold_len: got %0d want %0d", holds, R);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || msx_reset !== 1'b0) begin
      n_err++;
      $display("FAIL idle_done_pulse: got done %b msx_reset %b want 0 0", done, msx_reset);
    end
  endtask

  task automatic test_settle_restart;
    bit seen;
    int holds;
    int k = 0;
    sram_clear_en = 1'b1;
    sram_size     = 8'd1;
    ack_mode      = 1;
    push_range(1024);
    pulse_reload();
    repeat (2) @(posedge clk);
    pulse_reload();          // seen at settle count 3
    repeat (5) @(posedge clk);
    pulse_reload();          // seen at settle count 6
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(posedge clk);
      #1;
      if (mif.mem_req) k = i;
    end
    n_cmp++;
    if (k != S) begin
      n_err++;
      $display("FAIL settle_restart_delay: got %0d want %0d", k, S);
    end
    wait_done(3000, seen, holds);
    n_cmp++;
    if (!seen || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL settle_restart_done: got seen %b left %0d want 1 0", seen, exp_q.size());
    end
  endtask

  task automatic test_stall_full;
    bit seen;
    int holds;
    sram_clear_en = 1'b1;
    sram_size     = 8'd64;
    ack_mode      = 2;
    push_range(32768);
    pulse_reload();
    wait_done(80000, seen, holds);
    ack_mode = 1;
    n_cmp++;
    if (!seen || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL full_done: got seen %b left %0d want 1 0", seen, exp_q.size());
    end
    n_cmp++;
    if (last_wr_addr !== 15'h7FFF) begin
      n_err++;
      $display("FAIL full_last_addr: got %0h want 7fff", last_wr_addr);
    end
    n_cmp++;
    if (holds != R) begin
      n_err++;
      $display("FAIL full_hold_len: got %0d want %0d", holds, R);
    end
  endtask

  task automatic test_abort_clear;
    bit seen;
    int holds;
    bit found = 1'b0;
    sram_clear_en = 1'b1;
    sram_size     = 8'd1;
    ack_mode      = 1;
    stop_addr     = 15'd100;
    stop_en       = 1'b1;
    push_range(1024);
    pulse_reload();
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (mif.mem_req && mif.mem_addr == 15'd100) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL abort_reach_100: got not reached want reached");
    end
    pulse_reload();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mif.mem_req, state_dbg} !== {1'b1, ST_CLEAR} || mif.mem_addr !== 15'd100) begin
      n_err++;
      $display("FAIL abort_held: got req %b state %0d addr %0h want 1 2 64",
               mif.mem_req, state_dbg, mif.mem_addr);
    end
    stop_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if ({mif.mem_req, state_dbg} !== {1'b0, ST_SETTLE}) begin
      n_err++;
      $display("FAIL abort_to_settle: got req %b state %0d want 0 1", mif.mem_req, state_dbg);
    end
    n_cmp++;
    if (exp_q.size() != 923) begin
      n_err++;
      $display("FAIL abort_write_count: got left %0d want 923", exp_q.size());
    end
    exp_q.delete();
    push_range(1024);
    wait_done(3000, seen, holds);
    n_cmp++;
    if (!seen || exp_q.size() != 0 || holds != R) begin
      n_err++;
      $display("FAIL abort_redo: got seen %b left %0d holds %0d want 1 0 %0d",
               seen, exp_q.size(), holds, R);
    end
  endtask

  task automatic test_user_reset_hold;
    bit seen;
    int holds;
    sram_clear_en = 1'b1;
    sram_size     = 8'd0;   // nothing to clear: must go straight to HOLD
    @(posedge clk);
    #1 user_reset = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (state_dbg !== ST_SETTLE || msx_reset !== 1'b1) begin
      n_err++;
      $display("FAIL user_hold: got state %0d msx_reset %b want 1 1", state_dbg, msx_reset);
    end
    @(posedge clk);
    #1 user_reset = 1'b0;
    wait_done(100, seen, holds);
    n_cmp++;
    if (!seen || holds != R) begin
      n_err++;
      $display("FAIL user_release: got seen %b holds %0d want 1 %0d", seen, holds, R);
    end
  endtask

  task automatic test_reset_mid_clear;
    bit seen;
    int holds;
    bit found = 1'b0;
    sram_clear_en = 1'b1;
    sram_size     = 8'd2;
    ack_mode      = 1;
    push_range(2048);
    pulse_reload();
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (mif.mem_req && mif.mem_addr == 15'd500) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL rst_reach_500: got not reached want reached");
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({mif.mem_req, msx_reset, busy, done, state_dbg} !== {4'b0110, ST_IDLE} ||
        mif.mem_addr !== 15'd0) begin
      n_err++;
      $display("FAIL rst_async: got req %b rst %b busy %b done %b state %0d addr %0h want 0 1 1 0 0 0",
               mif.mem_req, msx_reset, busy, done, state_dbg, mif.mem_addr);
    end
    exp_q.delete();
    push_range(2048);
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_done(5000, seen, holds);
    n_cmp++;
    if (!seen || exp_q.size() != 0 || last_wr_addr !== 15'd2047) begin
      n_err++;
      $display("FAIL rst_rerun: got seen %b left %0d last %0h want 1 0 7ff",
               seen, exp_q.size(), last_wr_addr);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_power_up();
    test_reload_idle();
    test_settle_restart();
    test_stall_full();
    test_abort_clear();
    test_user_reset_hold();
    test_reset_mid_clear();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
